// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch unit with I-cache request FSM, redirect flush and decode FIFO
module fetch_queue #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h00000060,
    parameter int          LINE_BYTES = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [31:0]                i_addr,
    output logic                       i_read,
    input  logic [31:0]                i_data,
    input  logic                       i_resp,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [31:0]                deq_instr,
    output logic [31:0]                deq_pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [31:0]                prefetch_pc
);

    localparam int              CW        = $clog2(DEPTH + 1);
    localparam int              PW        = $clog2(DEPTH);
    localparam logic [CW-1:0]   FULL      = CW'(DEPTH);
    localparam logic [31:0]     LINE_SIZE = 32'(LINE_BYTES);
    localparam logic [31:0]     LINE_MASK = ~(LINE_SIZE - 32'd1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_next;
    logic [31:0]   disc_addr;
    logic [31:0]   disc_addr_next;
    logic [31:0]   redirect_aligned;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [CW-1:0] count_after_push;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          push;
    logic          pop;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    // Redirect targets are word aligned; the low two bits are simply dropped.
    assign redirect_aligned = redirect_pc & ~32'd3;

    assign deq_valid   = (count != '0);
    assign deq_pc      = pc_mem[head];
    assign deq_instr   = instr_mem[head];
    assign occupancy   = count;
    assign prefetch_pc = (fetch_pc & LINE_MASK) + LINE_SIZE;

    // A redirect flushes the queue, so it also cancels any pop in the same cycle.
    assign pop = deq_valid & deq_ready & ~redirect;

    // Occupancy after an enqueue this cycle, used to decide whether to keep fetching.
    assign count_after_push = pop ? count : count + CW'(1);

    // Fetch FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, cache request outputs and fetch address updates.
    always_comb begin
        state_next     = state;
        fetch_pc_next  = fetch_pc;
        disc_addr_next = disc_addr;
        push           = 1'b0;
        i_read         = 1'b0;
        i_addr         = fetch_pc;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_next = redirect_aligned;
                    state_next    = REQ;
                end else if (count < FULL) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                i_read = 1'b1;
                i_addr = fetch_pc;
                if (redirect) begin
                    fetch_pc_next = redirect_aligned;
                    if (!i_resp) begin
                        // Request still outstanding: keep presenting the old address until it completes.
                        disc_addr_next = fetch_pc;
                        state_next     = DISCARD;
                    end
                end else if (i_resp) begin
                    push          = 1'b1;
                    fetch_pc_next = fetch_pc + 32'd4;
                    state_next    = (count_after_push < FULL) ? REQ : IDLE;
                end
            end
            DISCARD: begin
                i_read = 1'b1;
                i_addr = disc_addr;
                if (redirect) begin
                    fetch_pc_next = redirect_aligned;
                end
                if (i_resp) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (redirect) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(push) - CW'(pop);
        end
    end

    // Fetch address and the address latched for an abandoned request.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            disc_addr <= RESET_PC;
        end else begin
            fetch_pc  <= fetch_pc_next;
            disc_addr <= disc_addr_next;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count <= count_next;
        end
    end

    // Queue storage; entries are only meaningful while counted, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]    <= fetch_pc;
            instr_mem[tail] <= i_data;
        end
    end

endmodule
